// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues byte addresses to a 1-cycle-latency instruction
// memory and presents a replayable, squashable instruction stream to decode.
module instruction_fetch #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic        dbg_fsm_state
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_e;

  // Decode handshake: instr_valid is the valid, !stall is the ready. A word is
  // consumed on an edge where both are high; while stalled, instr/instr_pc/
  // instr_valid hold. A redirect squashes the presented word on the same edge.

  state_e      state_q, state_d;
  logic [7:0]  fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [7:0]  req_pc_q, req_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        consume;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;

    consume       = instr_valid_q && !stall;
    instr_count_d = instr_count_q + {15'd0, consume};

    if (redirect) begin
      fetch_pc_d    = {redirect_addr[7:1], 1'b0};
      req_valid_d   = 1'b0;
      instr_valid_d = 1'b0;
      state_d       = S_RUN;
      halted_d      = 1'b0;
    end else if (state_q == S_HALTED) begin
      req_valid_d = 1'b0;
      if (consume) begin
        instr_valid_d = 1'b0;
      end
    end else if (stall) begin
      // The in-flight response is dropped, so rewind to refetch it later.
      req_valid_d = 1'b0;
      if (req_valid_q) begin
        fetch_pc_d = req_pc_q;
      end
    end else begin
      if (req_valid_q) begin
        instr_d       = imem_data;
        instr_pc_d    = req_pc_q;
        instr_valid_d = 1'b1;
        if (imem_data == HALT_WORD) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end
      end else begin
        instr_valid_d = 1'b0;
      end
      req_valid_d = 1'b1;
      req_pc_d    = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + 8'd2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= {RESET_PC[7:1], 1'b0};
      req_valid_q   <= 1'b0;
      req_pc_q      <= 8'h00;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 8'h00;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign imem_addr     = fetch_pc_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign halted        = halted_q;
  assign instr_count   = instr_count_q;
  assign dbg_fsm_state = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with exact cycle timing, then
// randomized stall/redirect traffic checked against a program-order model.
module tb_instruction_fetch;

  localparam logic [7:0]  RESET_PC  = 8'h00;
  localparam logic [15:0] HALT_WORD = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] instr_count;
  logic        dbg_fsm_state;

  logic [7:0]  mem [256];
  int          n_checks = 0;
  int          n_fail = 0;

  // Clock and memory model (one-cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk)
    imem_data <= {mem[{imem_addr[7:1], 1'b1}], mem[{imem_addr[7:1], 1'b0}]};

  instruction_fetch #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .instr_count   (instr_count),
    .dbg_fsm_state (dbg_fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [7:0] a);
    return {mem[{a[7:1], 1'b1}], mem[{a[7:1], 1'b0}]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nonzero();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] pc,
                            input logic [15:0] cnt, input logic h);
    chk({tag, ".valid"}, instr_valid, v);
    chk({tag, ".count"}, instr_count, cnt);
    chk({tag, ".halted"}, halted, h);
    if (v) begin
      chk({tag, ".pc"}, instr_pc, pc);
      chk({tag, ".instr"}, instr, word_at(pc));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".instr"}, instr, 16'h0000);
    chk({tag, ".instr_pc"}, instr_pc, 8'h00);
    chk({tag, ".valid"}, instr_valid, 1'b0);
    chk({tag, ".halted"}, halted, 1'b0);
    chk({tag, ".count"}, instr_count, 16'h0000);
    chk({tag, ".addr"}, imem_addr, RESET_PC);
  endtask

  // Random-phase model: program-order expectations only
  logic [7:0]  exp_pc;
  logic [15:0] m_cnt;
  logic        m_halted;
  logic        m_done;
  logic [7:0]  frozen;
  int          bub;

  initial begin
    fill_nonzero();
    mem[0] = 8'h21; mem[1] = 8'hFE; mem[2] = 8'h22;
    mem[3] = 8'hFB; mem[4] = 8'h58; mem[5] = 8'h23;
    mem[8'h20] = 8'h34; mem[8'h21] = 8'h12;
    mem[8'h3E] = 8'h00; mem[8'h3F] = 8'h00;
    mem[8'hFC] = 8'h11; mem[8'hFD] = 8'hAA; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'hCC;

    // Reset
    #1 reset_n = 1'b0;
    #1;
    check_zero("reset");
    chk("reset.fsm", dbg_fsm_state, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;

    // Sequential fetch
    tick(); expect_out("seq.t1", 1'b0, 8'h00, 16'd0, 1'b0);
    chk("seq.t1.addr", imem_addr, 8'h02);
    tick(); expect_out("seq.pc0", 1'b1, 8'h00, 16'd0, 1'b0);
    chk("seq.pc0.word", instr, 16'hFE21);
    tick(); expect_out("seq.pc2", 1'b1, 8'h02, 16'd1, 1'b0);
    chk("seq.pc2.word", instr, 16'hFB22);
    tick(); expect_out("seq.pc4", 1'b1, 8'h04, 16'd2, 1'b0);
    chk("seq.pc4.word", instr, 16'h2358);
    tick(); expect_out("seq.pc6", 1'b1, 8'h06, 16'd3, 1'b0);

    // Back to 0, then stall on pc 2
    redirect = 1'b1; redirect_addr = 8'h00;
    tick(); redirect = 1'b0;
    expect_out("rd0.b1", 1'b0, 8'h00, 16'd4, 1'b0);
    tick(); expect_out("rd0.b2", 1'b0, 8'h00, 16'd4, 1'b0);
    tick(); expect_out("rd0.pc0", 1'b1, 8'h00, 16'd4, 1'b0);
    tick(); expect_out("rd0.pc2", 1'b1, 8'h02, 16'd5, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall.hold", 1'b1, 8'h02, 16'd5, 1'b0);
    end
    stall = 1'b0;
    tick(); expect_out("stall.bubble", 1'b0, 8'h00, 16'd6, 1'b0);
    tick(); expect_out("stall.pc4", 1'b1, 8'h04, 16'd6, 1'b0);

    // Redirect with odd target while pc 4 is consumed
    redirect = 1'b1; redirect_addr = 8'h21;
    tick(); redirect = 1'b0;
    expect_out("rd.b1", 1'b0, 8'h00, 16'd7, 1'b0);
    tick(); expect_out("rd.b2", 1'b0, 8'h00, 16'd7, 1'b0);
    tick(); expect_out("rd.pc20", 1'b1, 8'h20, 16'd7, 1'b0);
    chk("rd.pc20.word", instr, 16'h1234);

    // Redirect together with stall: presented word is discarded, not counted
    redirect = 1'b1; stall = 1'b1; redirect_addr = 8'h40;
    tick(); redirect = 1'b0; stall = 1'b0;
    expect_out("rds.b1", 1'b0, 8'h00, 16'd7, 1'b0);
    tick(); expect_out("rds.b2", 1'b0, 8'h00, 16'd7, 1'b0);
    tick(); expect_out("rds.pc40", 1'b1, 8'h40, 16'd7, 1'b0);

    // HALT at 3E
    redirect = 1'b1; redirect_addr = 8'h3C;
    tick(); redirect = 1'b0;
    expect_out("h.b1", 1'b0, 8'h00, 16'd8, 1'b0);
    tick(); expect_out("h.b2", 1'b0, 8'h00, 16'd8, 1'b0);
    tick(); expect_out("h.pc3c", 1'b1, 8'h3C, 16'd8, 1'b0);
    tick(); expect_out("h.pc3e", 1'b1, 8'h3E, 16'd9, 1'b1);
    chk("h.pc3e.word", instr, 16'h0000);
    chk("h.pc3e.addr", imem_addr, 8'h42);
    tick(); expect_out("h.done", 1'b0, 8'h00, 16'd10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(); expect_out("h.idle", 1'b0, 8'h00, 16'd10, 1'b1);
      chk("h.idle.addr", imem_addr, 8'h42);
      chk("h.idle.fsm", dbg_fsm_state, 1'b1);
    end
    redirect = 1'b1; redirect_addr = 8'h00;
    tick(); redirect = 1'b0;
    expect_out("h.clr", 1'b0, 8'h00, 16'd10, 1'b0);
    chk("h.clr.fsm", dbg_fsm_state, 1'b0);
    tick(); expect_out("h.b2", 1'b0, 8'h00, 16'd10, 1'b0);
    tick(); expect_out("h.restart", 1'b1, 8'h00, 16'd10, 1'b0);

    // Address wrap, then asynchronous reset mid-stream
    redirect = 1'b1; redirect_addr = 8'hFC;
    tick(); redirect = 1'b0;
    expect_out("w.b1", 1'b0, 8'h00, 16'd11, 1'b0);
    tick(); expect_out("w.b2", 1'b0, 8'h00, 16'd11, 1'b0);
    tick(); expect_out("w.pcfc", 1'b1, 8'hFC, 16'd11, 1'b0);
    chk("w.pcfc.word", instr, 16'hAA11);
    tick(); expect_out("w.pcfe", 1'b1, 8'hFE, 16'd12, 1'b0);
    chk("w.pcfe.word", instr, 16'hCC33);
    tick(); expect_out("w.pc00", 1'b1, 8'h00, 16'd13, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_zero("arst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(); expect_out("arst.t1", 1'b0, 8'h00, 16'd0, 1'b0);
    tick(); expect_out("arst.pc0", 1'b1, 8'h00, 16'd0, 1'b0);

    // Randomized traffic
    reset_n = 1'b0;
    tick();
    for (int a = 0; a < 256; a += 2) begin
      if ($urandom_range(0, 15) == 0) begin
        mem[a] = 8'h00; mem[a + 1] = 8'h00;
      end else begin
        mem[a] = 8'($urandom_range(1, 255)); mem[a + 1] = 8'($urandom_range(1, 255));
      end
    end
    reset_n = 1'b1;
    exp_pc = RESET_PC; m_cnt = 16'd0; m_halted = 1'b0; m_done = 1'b0; frozen = 8'h00; bub = 0;

    for (int c = 0; c < 1500; c++) begin
      chk("rnd.count", instr_count, m_cnt);
      if (m_done) begin
        chk("rnd.idle_after_halt", instr_valid, 1'b0);
      end else if (instr_valid) begin
        chk("rnd.pc", instr_pc, exp_pc);
        chk("rnd.instr", instr, word_at(exp_pc));
        if (!m_halted && word_at(exp_pc) == HALT_WORD) begin
          m_halted = 1'b1;
          frozen = exp_pc + 8'd4;
        end
      end
      chk("rnd.halted", halted, m_halted);
      if (m_halted) chk("rnd.frozen_addr", imem_addr, frozen);

      stall = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < (m_halted ? 15 : 5));
      redirect_addr = 8'($urandom_range(0, 255));

      if (instr_valid && !stall) begin
        m_cnt = m_cnt + 16'd1;
        if (m_halted) m_done = 1'b1;
        else exp_pc = exp_pc + 8'd2;
      end
      if (redirect) begin
        exp_pc = {redirect_addr[7:1], 1'b0};
        m_halted = 1'b0;
        m_done = 1'b0;
      end
      if (instr_valid || stall || redirect || m_halted) begin
        bub = 0;
      end else begin
        bub++;
        chk("rnd.bubble_len", (bub <= 2), 1'b1);
      end
      tick();
    end
    stall = 1'b0;
    redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
